// File: rtl/icap_loader_pkg.sv
// icap_loader_pkg: shared definitions for the ICAP bitstream loader.
//   state_e           - loader state machine encoding
//   DefaultSyncWord   - pre-swap word that marks configuration sync
//   beats_per_word()  - number of ICAP beats needed for one 32-bit word
//   swap_bytes()      - bit-reverses each byte of a word in place
package icap_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } state_e;

    localparam logic [31:0] DefaultSyncWord = 32'hAA995566;

    function automatic int unsigned beats_per_word(input int unsigned width);
        case (width)
            8:       return 4;
            16:      return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 8; b++) begin
                r[i*8 + b] = w[i*8 + 7 - b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_stream_fifo.sv
// icap_stream_fifo: synchronous FIFO with a registered occupancy count.
//   clk_i / rst_i  - clock, synchronous active-high reset
//   push_i/wdata_i - write request and data (ignored while full)
//   pop_i          - read request (ignored while empty)
//   rdata_o        - head of the FIFO, valid while !empty_o
//   empty_o/full_o - decoded from the registered count only
module icap_stream_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a pop while full does not
    // make room for a push in the same cycle.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == DepthCnt);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
        rdata_o = mem_q[rptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/icap_stream_loader.sv
// icap_stream_loader: buffers a 32-bit bitstream stream and serialises it onto
// an ICAP port of 8, 16 or 32 bits, tracking sync, completion and word count.
//   CLK, RST            - clock, synchronous active-high reset
//   START               - pulse that begins a load (honoured in IDLE/FIN only)
//   S_DATA/S_VALID/S_READY/S_LAST - input word stream, S_LAST marks final word
//   ICAP_CSIB/RDWRB/I   - ICAP write port, CSIB low on valid beats
//   BUSY/DONE/SYNCED/ERR - status; DONE, SYNCED, ERR are sticky until START
//   WORD_CNT            - words fully emitted since START
module icap_stream_loader
    import icap_loader_pkg::*;
#(
    parameter int unsigned ICAP_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          BIT_SWAP   = 1'b1,
    parameter logic [31:0] SYNC_WORD  = DefaultSyncWord
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] S_DATA,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic        S_LAST,
    output logic        ICAP_CSIB,
    output logic        ICAP_RDWRB,
    output logic [31:0] ICAP_I,
    output logic        BUSY,
    output logic        DONE,
    output logic        SYNCED,
    output logic        ERR,
    output logic [31:0] WORD_CNT
);

    if (ICAP_WIDTH != 8 && ICAP_WIDTH != 16 && ICAP_WIDTH != 32) begin : g_bad_width
        $fatal(1, "icap_stream_loader: ICAP_WIDTH must be 8, 16 or 32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "icap_stream_loader: FIFO_DEPTH must be a power of 2 >= 2");
    end

    localparam int unsigned NumBeats = beats_per_word(ICAP_WIDTH);
    localparam logic [1:0]  LastBeat = 2'(NumBeats - 1);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic        synced_q, synced_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] ser_data_q, ser_data_d;
    logic [1:0]  beat_q, beat_d;
    logic        ser_valid_q, ser_valid_d;
    logic        ser_sync_q, ser_sync_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic [31:0] fifo_rdata;
    logic        fifo_pop;
    logic        s_xfer;
    logic        last_beat;

    icap_stream_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (32)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (s_xfer),
        .wdata_i (S_DATA),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        S_READY   = (state_q == StRun) && !fifo_full;
        s_xfer    = S_VALID && S_READY;
        last_beat = ser_valid_q && (beat_q == LastBeat);
        // Reload on the final beat keeps back-to-back words bubble-free.
        fifo_pop  = !fifo_empty && (!ser_valid_q || last_beat);

        state_d     = state_q;
        done_d      = done_q;
        synced_d    = synced_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        ser_data_d  = ser_data_q;
        beat_d      = beat_q;
        ser_valid_d = ser_valid_q;
        ser_sync_d  = ser_sync_q;

        if (ser_valid_q) begin
            if (last_beat) begin
                ser_valid_d = 1'b0;
                beat_d      = '0;
                cnt_d       = cnt_q + 32'd1;
                if (ser_sync_q) begin
                    synced_d = 1'b1;
                end
            end else begin
                beat_d     = beat_q + 2'd1;
                ser_data_d = ser_data_q << ICAP_WIDTH;
            end
        end

        if (fifo_pop) begin
            ser_valid_d = 1'b1;
            beat_d      = '0;
            ser_data_d  = BIT_SWAP ? swap_bytes(fifo_rdata) : fifo_rdata;
            // Sync is judged on the pre-swap word.
            ser_sync_d  = (fifo_rdata == SYNC_WORD);
        end

        unique case (state_q)
            StIdle, StFin: begin
                if (START) begin
                    state_d  = StRun;
                    done_d   = 1'b0;
                    synced_d = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                if (s_xfer && S_LAST) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Serializer is idle here, so synced_q is already final.
                if (fifo_empty && !ser_valid_q) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                    err_d   = !synced_q;
                end
            end
            default: state_d = StIdle;
        endcase

        ICAP_CSIB  = !ser_valid_q;
        ICAP_RDWRB = 1'b0;
        ICAP_I     = ser_valid_q ? 32'(ser_data_q[31 -: ICAP_WIDTH]) : 32'h0;
        BUSY       = (state_q == StRun) || (state_q == StDrain);
        DONE       = done_q;
        SYNCED     = synced_q;
        ERR        = err_q;
        WORD_CNT   = cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            synced_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            ser_data_q  <= '0;
            beat_q      <= '0;
            ser_valid_q <= 1'b0;
            ser_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            synced_q    <= synced_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            ser_data_q  <= ser_data_d;
            beat_q      <= beat_d;
            ser_valid_q <= ser_valid_d;
            ser_sync_q  <= ser_sync_d;
        end
    end

endmodule

// File: tb/tb_icap_stream_loader.sv
// tb_icap_stream_loader: directed bench for three loader configurations:
//   [0] X32, BIT_SWAP=1, depth 16   [1] X8, BIT_SWAP=0, depth 16
//   [2] X16, BIT_SWAP=1, depth 4
module tb_icap_stream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [3];
    logic        start   [3];
    logic [31:0] s_data  [3];
    logic        s_valid [3];
    logic        s_ready [3];
    logic        s_last  [3];
    logic        csib    [3];
    logic        rdwrb   [3];
    logic [31:0] icap_i  [3];
    logic        busy    [3];
    logic        done    [3];
    logic        synced  [3];
    logic        err     [3];
    logic [31:0] word_cnt[3];

    icap_stream_loader #(
        .ICAP_WIDTH (32),
        .FIFO_DEPTH (16),
        .BIT_SWAP   (1'b1),
        .SYNC_WORD  (32'hAA995566)
    ) u_x32 (
        .CLK (clk), .RST (rst[0]), .START (start[0]), .S_DATA (s_data[0]),
        .S_VALID (s_valid[0]), .S_READY (s_ready[0]), .S_LAST (s_last[0]),
        .ICAP_CSIB (csib[0]), .ICAP_RDWRB (rdwrb[0]), .ICAP_I (icap_i[0]),
        .BUSY (busy[0]), .DONE (done[0]), .SYNCED (synced[0]), .ERR (err[0]),
        .WORD_CNT (word_cnt[0])
    );

    icap_stream_loader #(
        .ICAP_WIDTH (8),
        .FIFO_DEPTH (16),
        .BIT_SWAP   (1'b0),
        .SYNC_WORD  (32'hAA995566)
    ) u_x8 (
        .CLK (clk), .RST (rst[1]), .START (start[1]), .S_DATA (s_data[1]),
        .S_VALID (s_valid[1]), .S_READY (s_ready[1]), .S_LAST (s_last[1]),
        .ICAP_CSIB (csib[1]), .ICAP_RDWRB (rdwrb[1]), .ICAP_I (icap_i[1]),
        .BUSY (busy[1]), .DONE (done[1]), .SYNCED (synced[1]), .ERR (err[1]),
        .WORD_CNT (word_cnt[1])
    );

    icap_stream_loader #(
        .ICAP_WIDTH (16),
        .FIFO_DEPTH (4),
        .BIT_SWAP   (1'b1),
        .SYNC_WORD  (32'hAA995566)
    ) u_x16 (
        .CLK (clk), .RST (rst[2]), .START (start[2]), .S_DATA (s_data[2]),
        .S_VALID (s_valid[2]), .S_READY (s_ready[2]), .S_LAST (s_last[2]),
        .ICAP_CSIB (csib[2]), .ICAP_RDWRB (rdwrb[2]), .ICAP_I (icap_i[2]),
        .BUSY (busy[2]), .DONE (done[2]), .SYNCED (synced[2]), .ERR (err[2]),
        .WORD_CNT (word_cnt[2])
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic [95:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view: ready, csib, rdwrb, busy, done, synced, err, icap_i, word_cnt.
    function automatic logic [95:0] outs(input int k);
        return {25'b0, s_ready[k], csib[k], rdwrb[k], busy[k], done[k], synced[k], err[k],
                icap_i[k], word_cnt[k]};
    endfunction

    function automatic logic [95:0] ex(input logic r, input logic c, input logic b,
                                       input logic d, input logic s, input logic e,
                                       input logic [31:0] i, input logic [31:0] n);
        return {25'b0, r, c, 1'b0, b, d, s, e, i, n};
    endfunction

    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[(i / 8) * 8 + 7 - (i % 8)] = w[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] w16(input int i);
        return 32'h8001_0F37 + 32'(i) * 32'h0111_1111;
    endfunction

    task automatic wait_done(input int k, input string name);
        for (int n = 0; n < 40 && !done[k]; n++) begin
            tick();
        end
        check(name, 96'(done[k]), 96'(1));
    endtask

    // Gap-run monitor state (instance 0).
    int          g_nb;
    int          g_bad;
    int          g_gap;
    logic [31:0] g_beats[3];

    task automatic mon_gap();
        if (csib[0]) begin
            if (icap_i[0] != 32'h0) g_bad++;
            if (g_nb > 0 && g_nb < 3) g_gap++;
        end else begin
            if (g_nb < 3) g_beats[g_nb] = icap_i[0];
            g_nb++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_b;
        logic [31:0] sw;
        logic [31:0] gw[3];
        logic [31:0] beats16[16];
        int          cyc16[16];
        int          nb16;
        int          acc;
        int          first_low;
        logic        xfer;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; s_data[k] = '0; s_valid[k] = 1'b0; s_last[k] = 1'b0;
        end
        tick(); tick(); tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset outputs inst %0d", k), outs(k), ex(0, 1, 0, 0, 0, 0, 0, 0));
        end

        // ---- X32 table: sync load, START in DRAIN ignored, START in FIN restarts.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,          ex(0, 1, 0, 0, 0, 0, 32'h0, 0)};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF,   ex(1, 1, 1, 0, 0, 0, 32'h0, 0)};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'hAA995566,   ex(1, 1, 1, 0, 0, 0, 32'h0, 0)};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h20000000,   ex(1, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 0)};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,          ex(0, 0, 1, 0, 0, 0, 32'h5599AA66, 1)};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,          ex(0, 0, 1, 0, 1, 0, 32'h04000000, 2)};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,          ex(0, 1, 1, 0, 1, 0, 32'h0, 3)};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0,          ex(0, 1, 0, 1, 1, 0, 32'h0, 3)};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,          ex(1, 1, 1, 0, 0, 0, 32'h0, 0)};
        for (int i = 0; i < 9; i++) begin
            start[0] = tbl[i].start; s_valid[0] = tbl[i].valid;
            s_last[0] = tbl[i].last; s_data[0] = tbl[i].data;
            check($sformatf("x32 vec %0d", i), outs(0), tbl[i].exp);
            tick();
        end
        start[0] = 1'b0; s_valid[0] = 1'b0; s_last[0] = 1'b0;

        // ---- X8, no swap: single last word, beat order and latency.
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        s_valid[1] = 1'b1; s_data[1] = 32'h12345678; s_last[1] = 1'b1;
        check("x8 ready in run", 96'(s_ready[1]), 96'(1));
        tick();
        s_valid[1] = 1'b0; s_last[1] = 1'b0;
        check("x8 latency idle cycle", 96'(csib[1]), 96'(1));
        tick();
        for (int b = 0; b < 4; b++) begin
            exp_b = (32'h12345678 >> (8 * (3 - b))) & 32'hFF;
            check($sformatf("x8 beat %0d", b), 96'({csib[1], icap_i[1]}), 96'({1'b0, exp_b}));
            tick();
        end
        wait_done(1, "x8 done timeout");
        check("x8 final status", 96'({busy[1], done[1], synced[1], err[1], word_cnt[1]}),
              96'({1'b0, 1'b1, 1'b0, 1'b1, 32'd1}));

        // ---- X8 reset on the second beat, then a clean sync load.
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        s_valid[1] = 1'b1; s_data[1] = 32'hAABBCCDD; s_last[1] = 1'b1;
        tick();
        s_valid[1] = 1'b0; s_last[1] = 1'b0;
        tick(); tick();
        check("x8 second beat before reset", 96'({csib[1], icap_i[1]}), 96'({1'b0, 32'hBB}));
        rst[1] = 1'b1; tick(); rst[1] = 1'b0;
        check("x8 outputs after mid-word reset", outs(1), ex(0, 1, 0, 0, 0, 0, 0, 0));
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        s_valid[1] = 1'b1; s_data[1] = 32'hAA995566; s_last[1] = 1'b1;
        tick();
        s_valid[1] = 1'b0; s_last[1] = 1'b0;
        wait_done(1, "x8 reload done timeout");
        check("x8 reload status", 96'({busy[1], done[1], synced[1], err[1], word_cnt[1]}),
              96'({1'b0, 1'b1, 1'b1, 1'b0, 32'd1}));

        // ---- X16, depth 4: S_VALID held for 8 words, back-pressure and order.
        start[2] = 1'b1; tick(); start[2] = 1'b0;
        acc = 0; nb16 = 0; first_low = -1;
        for (int c = 0; c < 80; c++) begin
            s_valid[2] = (acc < 8);
            s_data[2]  = w16(acc);
            s_last[2]  = (acc == 7);
            if (!csib[2]) begin
                if (nb16 < 16) begin
                    beats16[nb16] = icap_i[2];
                    cyc16[nb16]   = c;
                end
                nb16++;
            end
            if (s_valid[2] && !s_ready[2] && first_low < 0) first_low = acc;
            xfer = s_valid[2] && s_ready[2];
            if (done[2]) break;
            tick();
            if (xfer) acc++;
        end
        s_valid[2] = 1'b0; s_last[2] = 1'b0;
        // Ready first drops with w3..w6 buffered, w2 serialising, w0/w1 emitted.
        check("x16 words accepted before ready drop", 96'(first_low), 96'(7));
        check("x16 beat count", 96'(nb16), 96'(16));
        check("x16 no csib gap", 96'(cyc16[15] - cyc16[0]), 96'(15));
        for (int j = 0; j < 16; j++) begin
            sw = ref_swap(w16(j / 2));
            exp_b = (j % 2 == 0) ? (sw >> 16) : (sw & 32'hFFFF);
            check($sformatf("x16 beat %0d", j), 96'(beats16[j]), 96'(exp_b));
        end
        check("x16 final status", 96'({done[2], synced[2], err[2], word_cnt[2]}),
              96'({1'b1, 1'b0, 1'b1, 32'd8}));

        // ---- X32 with 3-cycle S_VALID gaps between words.
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        gw[0] = 32'hFFFFFFFF; gw[1] = 32'hAA995566; gw[2] = 32'h20000000;
        g_nb = 0; g_bad = 0; g_gap = 0;
        for (int w = 0; w < 3; w++) begin
            s_valid[0] = 1'b1; s_data[0] = gw[w]; s_last[0] = (w == 2);
            for (int n = 0; n < 10 && !s_ready[0]; n++) begin
                mon_gap(); tick();
            end
            mon_gap(); tick();
            s_valid[0] = 1'b0; s_last[0] = 1'b0;
            for (int n = 0; n < 3; n++) begin
                mon_gap(); tick();
            end
        end
        for (int n = 0; n < 20 && !done[0]; n++) begin
            mon_gap(); tick();
        end
        check("gap icap_i zero while csib high", 96'(g_bad), 96'(0));
        check("gap idle cycles between beats", 96'(g_gap), 96'(6));
        check("gap beat count", 96'(g_nb), 96'(3));
        check("gap beat 0", 96'(g_beats[0]), 96'(32'hFFFFFFFF));
        check("gap beat 1", 96'(g_beats[1]), 96'(32'h5599AA66));
        check("gap beat 2", 96'(g_beats[2]), 96'(32'h04000000));
        check("gap final status", 96'({busy[0], done[0], synced[0], err[0], word_cnt[0]}),
              96'({1'b0, 1'b1, 1'b1, 1'b0, 32'd3}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
